// File: rtl/digit_unit_arbiter_if.sv
// rtl/digit_unit_arbiter_if.sv - requester and unit-side signal bundle for digit_unit_arbiter
interface digit_unit_arbiter_if;
    logic       req0_valid;
    logic       req0_op;
    logic       req0_slot;
    logic [3:0] req0_data;
    logic       req0_ready;

    logic       req1_valid;
    logic       req1_op;
    logic       req1_slot;
    logic [3:0] req1_data;
    logic       req1_ready;

    logic       unit_select;
    logic       unit_add;
    logic       unit_next;
    logic [3:0] unit_data;

    logic       mode;
    logic       busy;
    logic       grant_id;
    logic       drop;

    // Arbiter side: consumes requests, drives the unit lines and status
    modport slave (
        input  req0_valid, req0_op, req0_slot, req0_data,
        input  req1_valid, req1_op, req1_slot, req1_data,
        output req0_ready, req1_ready,
        output unit_select, unit_add, unit_next, unit_data,
        output mode, busy, grant_id, drop
    );

    // Requester / observer side
    modport master (
        output req0_valid, req0_op, req0_slot, req0_data,
        output req1_valid, req1_op, req1_slot, req1_data,
        input  req0_ready, req1_ready,
        input  unit_select, unit_add, unit_next, unit_data,
        input  mode, busy, grant_id, drop
    );
endinterface

// File: rtl/digit_unit_arbiter.sv
// rtl/digit_unit_arbiter.sv - round-robin sharer of one digit buffer/GCD unit with timed strobes
module digit_unit_arbiter #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 2
) (
    input  logic clk,
    input  logic rst_n,
    digit_unit_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_W - 1);
    localparam logic       OP_ADD   = 1'b0;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_mode_flip;

    logic       r_op;
    logic       r_last_grant;
    logic       r_grant_id;
    logic       r_unit_select;
    logic [3:0] r_unit_data;
    logic       r_unit_add;
    logic       r_unit_next;
    logic       r_mode;
    logic       r_busy;
    logic       r_drop;

    logic       w_idle;
    logic       w_pick;
    logic       w_ready0;
    logic       w_ready1;
    logic       w_accept;
    logic       w_acc_op;
    logic       w_acc_slot;
    logic [3:0] w_acc_data;
    logic       w_op_nxt;

    assign w_idle = (r_state == S_IDLE);

    // Round-robin pick: a tie goes to whoever was not served last
    always_comb begin
        w_pick     = 1'b0;
        w_ready0   = 1'b0;
        w_ready1   = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_pick = ~r_last_grant;
        end else begin
            w_pick = bus.req1_valid;
        end
        w_ready0   = w_idle && bus.req0_valid && !w_pick;
        w_ready1   = w_idle && bus.req1_valid &&  w_pick;
        w_accept   = w_ready0 || w_ready1;
        w_acc_op   = w_pick ? bus.req1_op   : bus.req0_op;
        w_acc_slot = w_pick ? bus.req1_slot : bus.req0_slot;
        w_acc_data = w_pick ? bus.req1_data : bus.req0_data;
        w_op_nxt   = w_accept ? w_acc_op : r_op;
    end

    // Next-state: an ADD in gcd mode never leaves IDLE, everything else strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_flip = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (w_acc_op != OP_ADD || !r_mode)) begin
                    w_state_nxt = S_DRIVE;
                    w_cnt_nxt   = PULSE_LD;
                end
            end
            S_DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = GAP_LD;
                    w_mode_flip = (r_op != OP_ADD);
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State and phase counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered unit lines, shadow mode and grant bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op          <= 1'b0;
            r_last_grant  <= 1'b1;
            r_grant_id    <= 1'b0;
            r_unit_select <= 1'b0;
            r_unit_data   <= 4'd0;
            r_unit_add    <= 1'b0;
            r_unit_next   <= 1'b0;
            r_mode        <= 1'b0;
            r_busy        <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op         <= w_acc_op;
                r_last_grant <= w_pick;
                r_grant_id   <= w_pick;
                if (w_acc_op == OP_ADD) begin
                    // In gcd mode select still moves: it picks the displayed digit
                    r_unit_select <= w_acc_slot;
                    if (!r_mode) begin
                        r_unit_data <= w_acc_data;
                    end
                end
            end
            r_drop      <= w_accept && (w_acc_op == OP_ADD) && r_mode;
            r_mode      <= r_mode ^ w_mode_flip;
            r_unit_add  <= (w_state_nxt == S_DRIVE) && (w_op_nxt == OP_ADD);
            r_unit_next <= (w_state_nxt == S_DRIVE) && (w_op_nxt != OP_ADD);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.req0_ready  = w_ready0;
    assign bus.req1_ready  = w_ready1;
    assign bus.unit_select = r_unit_select;
    assign bus.unit_data   = r_unit_data;
    assign bus.unit_add    = r_unit_add;
    assign bus.unit_next   = r_unit_next;
    assign bus.mode        = r_mode;
    assign bus.busy        = r_busy;
    assign bus.grant_id    = r_grant_id;
    assign bus.drop        = r_drop;
endmodule
